// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the operand bypass unit.
// Holds the in-flight tag layout, the XZR index and the forward-select width.
package cpu_pipe_pkg;

  localparam int ZERO_REG = 31;
  localparam int TAG_RD_W = 5;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic                is_load;
    logic [TAG_RD_W-1:0] rd;
  } pipe_tag_t;

  // Select encodes regfile (0) plus one code per tracked stage.
  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bypass_select.sv
// Single-source forwarding matcher: picks the youngest in-flight writer of the
// source register and muxes its stage result over the regfile value.
module bypass_select
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 2,
  parameter int LOAD_STAGE   = 1,
  parameter int ZERO_REG_IDX = 31,
  parameter int SEL_W        = fwd_sel_w(DEPTH)
) (
  input  pipe_tag_t [DEPTH-1:0]        tag_i,
  input  logic      [REG_AW-1:0]       src_addr_i,
  input  logic      [DATA_W-1:0]       src_data_i,
  input  logic      [DEPTH*DATA_W-1:0] stage_result_i,
  output logic      [DATA_W-1:0]       op_data_o,
  output logic      [SEL_W-1:0]        fwd_sel_o,
  output logic                         load_hazard_o
);

  logic is_zero;

  assign is_zero = (src_addr_i == REG_AW'(ZERO_REG_IDX));

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path leaves one unassigned (no latch).
    op_data_o     = src_data_i;
    fwd_sel_o     = '0;
    load_hazard_o = 1'b0;
    if (is_zero) begin
      op_data_o = '0;
    end else begin
      // Walk oldest to youngest so the lowest matching stage is written last and wins.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (tag_i[k].valid && tag_i[k].we && (tag_i[k].rd == src_addr_i)) begin
          op_data_o     = stage_result_i[k*DATA_W +: DATA_W];
          fwd_sel_o     = SEL_W'(k + 1);
          load_hazard_o = tag_i[k].is_load && (k < LOAD_STAGE);
        end
      end
    end
  end

endmodule

// File: rtl/operand_bypass_unit.sv
// Operand forwarding and load-use hazard unit: a DEPTH-deep tag pipeline of
// in-flight destinations drives per-source bypass muxes, stall and write-back controls.
module operand_bypass_unit #(
  parameter int DATA_W     = 64,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 1,
  parameter int ZERO_REG   = cpu_pipe_pkg::ZERO_REG
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 id_valid,
  input  logic                                                 id_we,
  input  logic                                                 id_is_load,
  input  logic [REG_AW-1:0]                                    id_rd,
  input  logic [NUM_SRC*REG_AW-1:0]                            id_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]                            id_src_data,
  input  logic                                                 flush,
  input  logic [DEPTH*DATA_W-1:0]                              stage_result,
  output logic [NUM_SRC*DATA_W-1:0]                            op_data,
  output logic [NUM_SRC*cpu_pipe_pkg::fwd_sel_w(DEPTH)-1:0]    fwd_sel,
  output logic                                                 stall,
  output logic                                                 wb_valid,
  output logic                                                 wb_we,
  output logic [REG_AW-1:0]                                    wb_rd
);

  import cpu_pipe_pkg::*;

  localparam int SEL_W = fwd_sel_w(DEPTH);

  pipe_tag_t [DEPTH-1:0] tag_q, tag_d;
  logic      [NUM_SRC-1:0] hazard;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    bypass_select #(
      .DATA_W       (DATA_W),
      .REG_AW       (REG_AW),
      .DEPTH        (DEPTH),
      .LOAD_STAGE   (LOAD_STAGE),
      .ZERO_REG_IDX (ZERO_REG),
      .SEL_W        (SEL_W)
    ) u_sel (
      .tag_i          (tag_q),
      .src_addr_i     (id_src_addr[gi*REG_AW +: REG_AW]),
      .src_data_i     (id_src_data[gi*DATA_W +: DATA_W]),
      .stage_result_i (stage_result),
      .op_data_o      (op_data[gi*DATA_W +: DATA_W]),
      .fwd_sel_o      (fwd_sel[gi*SEL_W +: SEL_W]),
      .load_hazard_o  (hazard[gi])
    );
  end

  // Stall is reported even under flush; flush only decides what enters stage 0.
  assign stall = id_valid & (|hazard);

  always_comb begin
    tag_d = tag_q;
    for (int k = 1; k < DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    if (stall || flush || !id_valid) begin
      tag_d[0] = '0;
    end else begin
      tag_d[0] = '{valid: 1'b1, we: id_we, is_load: id_is_load, rd: id_rd};
    end
  end

  // NOTE: the tags are plain flops, not a RAM, so they take the async reset; a stale valid tag would forward garbage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the pre-edge value of its neighbour.
      tag_q <= tag_d;
    end
  end

  assign wb_valid = tag_q[DEPTH-1].valid;
  assign wb_we    = tag_q[DEPTH-1].we;
  assign wb_rd    = tag_q[DEPTH-1].rd;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit: the driver queues hand-computed
// expectations, a monitor drains and compares them on each falling edge.
module tb_operand_bypass_unit;

  localparam int DATA_W  = 64;
  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 2;
  localparam int SEL_W   = 2;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        id_valid, id_we, id_is_load, flush;
  logic [REG_AW-1:0]           id_rd;
  logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
  logic [NUM_SRC*DATA_W-1:0]   id_src_data;
  logic [DEPTH*DATA_W-1:0]     stage_result;
  logic [NUM_SRC*DATA_W-1:0]   op_data;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                        stall, wb_valid, wb_we;
  logic [REG_AW-1:0]           wb_rd;

  always #5 clk = ~clk;

  operand_bypass_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .id_rd        (id_rd),
    .id_src_addr  (id_src_addr),
    .id_src_data  (id_src_data),
    .flush        (flush),
    .stage_result (stage_result),
    .op_data      (op_data),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd)
  );

  typedef struct {
    string       name;
    logic [63:0] op0;
    bit          c0;
    logic [63:0] op1;
    bit          c1;
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic        stall;
    logic        wbv;
    logic        wbwe;
    logic [4:0]  wbrd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  event chk_ev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: drains every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.c0) check({e.name, ".op0"}, op_data[63:0], e.op0);
        if (e.c1) check({e.name, ".op1"}, op_data[127:64], e.op1);
        check({e.name, ".sel0"},  64'(fwd_sel[1:0]), 64'(e.sel0));
        check({e.name, ".sel1"},  64'(fwd_sel[3:2]), 64'(e.sel1));
        check({e.name, ".stall"}, 64'(stall),        64'(e.stall));
        check({e.name, ".wbv"},   64'(wb_valid),     64'(e.wbv));
        check({e.name, ".wbwe"},  64'(wb_we),        64'(e.wbwe));
        check({e.name, ".wbrd"},  64'(wb_rd),        64'(e.wbrd));
      end
    end
  end

  task automatic drive(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic fl,
                       input logic [63:0] sr0, input logic [63:0] sr1);
    id_valid     = v;
    id_we        = we;
    id_is_load   = ld;
    id_rd        = rd;
    id_src_addr  = {s1, s0};
    id_src_data  = {d1, d0};
    flush        = fl;
    stage_result = {sr1, sr0};
  endtask

  task automatic exp_push(input string name, input logic [63:0] op0, input bit c0,
                          input logic [63:0] op1, input bit c1,
                          input logic [1:0] sel0, input logic [1:0] sel1, input logic st,
                          input logic wbv, input logic wbwe, input logic [4:0] wbrd);
    exp_t e;
    e.name = name; e.op0 = op0; e.c0 = c0; e.op1 = op1; e.c1 = c1;
    e.sel0 = sel0; e.sel1 = sel1; e.stall = st;
    e.wbv = wbv; e.wbwe = wbwe; e.wbrd = wbrd;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 31, 64'h11, 64'h22, 0, 0, 0);
    exp_push("reset", 64'h11, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // EX and MEM forward of X1.
    drive(1, 1, 0, 1, 31, 31, 0, 0, 0, 0, 0);
    exp_push("t1_issue", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 1, 2, 0, 64'h77, 0, 2, 64'h99);
    exp_push("t1_ex_fwd", 2, 1, 64'h77, 1, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 2, 0, 64'h77, 0, 2, 64'h99);
    exp_push("t1_mem_fwd", 64'h99, 1, 64'h77, 1, 2, 0, 0, 1, 1, 1);
    tick();

    // Two writers of X3: youngest wins, then the older one once EX is a bubble.
    drive(1, 1, 0, 3, 3, 31, 64'h30, 64'h31, 0, 5, 9);
    exp_push("t2_first", 64'h30, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 1, 0, 3, 3, 31, 64'h30, 0, 0, 5, 9);
    exp_push("t2_ex", 5, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 3, 3, 64'h30, 64'h30, 0, 5, 9);
    exp_push("t2_youngest", 5, 1, 5, 1, 1, 1, 0, 1, 1, 3);
    tick();
    drive(0, 0, 0, 0, 3, 3, 64'h30, 64'h30, 0, 5, 9);
    exp_push("t2_mem", 9, 1, 9, 1, 2, 2, 0, 1, 1, 3);
    tick();

    // XZR writer in flight never forwards.
    drive(1, 1, 0, 31, 0, 0, 64'hA, 64'hB, 0, 0, 0);
    exp_push("t3_issue", 64'hA, 1, 64'hB, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 31, 31, 64'hDEAD, 64'hBEEF, 0, 64'h1234, 64'h5678);
    exp_push("t3_xzr", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Load-use: one stall cycle, then forward from MEM.
    drive(1, 1, 1, 5, 6, 31, 64'h600, 0, 0, 0, 0);
    exp_push("t4_ldur", 64'h600, 1, 0, 1, 0, 0, 0, 1, 1, 31);
    tick();
    drive(1, 1, 0, 5, 5, 31, 64'h55, 0, 0, 64'hBAD, 0);
    exp_push("t4_stall", 0, 0, 0, 1, 1, 0, 1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 5, 5, 31, 64'h55, 0, 0, 64'hBAD, 3);
    exp_push("t4_release", 3, 1, 0, 1, 2, 0, 0, 1, 1, 5);
    tick();

    // Flush kills the decode instruction.
    drive(1, 1, 0, 7, 5, 31, 0, 0, 1, 64'h42, 0);
    exp_push("t5_flush", 64'h42, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 7, 31, 64'h70, 0, 0, 0, 0);
    exp_push("t5_after", 64'h70, 1, 0, 1, 0, 0, 0, 1, 1, 5);
    tick();
    drive(1, 1, 1, 9, 7, 31, 64'h70, 0, 0, 0, 0);
    exp_push("t5_wb", 64'h70, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 10, 9, 31, 0, 0, 1, 64'h91, 0);
    exp_push("t5_flush_stall", 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 10, 9, 64'hA0, 0, 0, 0, 64'h90);
    exp_push("t5_killed", 64'hA0, 1, 64'h90, 1, 0, 2, 0, 1, 1, 9);
    tick();

    // Async reset with valid tags and a live stall.
    drive(1, 1, 0, 11, 0, 31, 1, 0, 0, 0, 0);
    exp_push("t6_r", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 12, 0, 31, 1, 0, 0, 0, 0);
    exp_push("t6_s", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 13, 12, 31, 64'hC0, 0, 0, 0, 0);
    exp_push("t6_stall", 0, 0, 0, 1, 1, 0, 1, 1, 1, 11);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    exp_push("t6_async", 64'hC0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    ->chk_ev;
    tick();
    reset = 1'b1;
    exp_push("t6_release", 64'hC0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_bypass_unit.md
Name: operand_bypass_unit

Overview:
- Parametrised operand-forwarding and hazard unit for the pipelined CPU datapath.
- Replaces the externally driven forward-control selects and fixed two-source, three-way forwarding muxes with a self-contained tag pipeline.
- Tracks in-flight destination registers across DEPTH post-decode stages and generates per-source forwarded operands and selects.
- Detects load-use hazards (stall plus bubble), kills the decode-stage instruction on flush, and emits the write-back register controls.

Parameters:
- DATA_W, 64, operand/result width.
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction (Rn, Rm/Rd).
- DEPTH, 2, in-flight stages tracked; index 0 = EX, DEPTH-1 = last stage before regfile write (default EX, MEM).
- LOAD_STAGE, 1, first stage index whose result is valid for a load.
- ZERO_REG, 31, hard-wired zero register (XZR).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- id_valid  in  1  decode-stage instruction valid.
- id_we  in  1  decode instruction writes a register.
- id_is_load  in  1  decode instruction is a load (LDUR).
- id_rd  in  REG_AW  decode destination register.
- id_src_addr  in  NUM_SRC*REG_AW  source register addresses; slot i = bits [i*REG_AW +: REG_AW].
- id_src_data  in  NUM_SRC*DATA_W  regfile read data per source.
- flush  in  1  kill the decode instruction (taken branch).
- stage_result  in  DEPTH*DATA_W  result currently held by each stage: slot 0 = ALU output, slot 1 = memory/ALU write-back value.
- op_data  out  NUM_SRC*DATA_W  forwarded operand per source.
- fwd_sel  out  NUM_SRC*$clog2(DEPTH+1)  per source: 0 = regfile, k+1 = stage k.
- stall  out  1  load-use hazard; upstream holds PC and decode.
- wb_valid, wb_we  out  1 each  last-stage entry flags.
- wb_rd  out  REG_AW  last-stage destination register.

Behaviour:
- State: DEPTH entries {valid, we, is_load, rd}.
- Reset: all entries cleared. Combinationally, outputs are wb_valid=0, wb_we=0, wb_rd=0, stall=0, fwd_sel=0, and op_data equals id_src_data (ZERO_REG slots read 0).
- Shift each cycle: entry[k] <= entry[k-1] for k ≥ 1.
- Entry 0 load:
  - If stall or flush or !id_valid, entry0 <= bubble (valid=0).
  - Otherwise entry0 <= {1, id_we, id_is_load, id_rd}.
- Latency: an instruction accepted at edge n occupies stage k during cycle n+k and appears on wb_* during cycle n+DEPTH-1.
- Match: source i matches stage k when entry[k].valid & entry[k].we & rd == src_i & src_i != ZERO_REG.
- Priority: among matches, the lowest k (youngest) wins; older matches are ignored.
- Forwarding select and data:
  - No match gives fwd_sel 0 and op_data = id_src_data.
  - A winning stage k gives fwd_sel k+1 and op_data = stage_result slot k.
- Zero register: src_i == ZERO_REG always gives op_data = 0 and fwd_sel = 0, whatever id_src_data or any match holds.
- Load-use stall:
  - Condition: id_valid & any source's winning stage k has is_load & k < LOAD_STAGE.
  - While stalling, that source's op_data is don't-care and its fwd_sel still reports k+1.
- Stall duration: exactly LOAD_STAGE - k cycles, because the tag advances one stage per cycle.
- Simultaneous flush and stall: flush wins; stall output is still computed from id_* but only a bubble is inserted. Upstream must give flush priority.
- Write-back overlap: the regfile writes on the falling edge, so data in the last stage is also forwarded directly. No extra write-back slot is needed.
- Reset mid-operation: all in-flight tags are lost asynchronously; no stall persists after reset release.
- All paths from id_* to op_data/fwd_sel/stall are combinational. Only the tag entries are registered.

Decomposition:
- Package cpu_pipe_pkg holds:
  - typedef pipe_tag_t {valid, we, is_load, rd};
  - the ZERO_REG constant;
  - the fwd_sel width function.
- One sub-module, bypass_select: a single-source priority matcher plus DATA_W (DEPTH+1):1 mux, instantiated NUM_SRC times by generate.

Test Plan:
1. EX forward: ADDI X1,X31,#2 accepted, then next cycle src0=X1 with stage_result[0]=2 and regfile X1=0 -> op_data0=2, fwd_sel0=1, stall=0.
2. MEM forward and youngest wins:
   - X3 written by two back-to-back instructions, stage_result={5,9} (stage0=5) -> src=X3 gives op_data=5, fwd_sel=1.
   - With the EX writer a bubble -> op_data=9, fwd_sel=2.
3. XZR: ADDS X31 in flight and src=X31 with id_src_data=0xDEAD -> op_data=0, fwd_sel=0.
4. Load-use: LDUR X5 accepted, then ADDI X5,X5,#0 -> stall=1 for exactly 1 cycle and entry0 is a bubble. Next cycle, stage_result[1]=3 -> op_data=3, fwd_sel=2, stall=0.
5. Flush: id_valid=1, id_we=1, rd=X7 with flush=1 -> one cycle later src=X7 gives fwd_sel=0. Two cycles later wb_valid=0.
6. Async reset mid-stream: drive reset=0 between edges with entries valid -> wb_valid=0 and stall=0 immediately, before the next clk edge.
